// File: rtl/mutex_lock_master.sv
// Avalon-MM master that acquires/releases a hardware mutex for local logic.
// Optional MUTEX_RESET_CLEAR_EN: clear the slave reset flag once after reset.
module mutex_lock_master #(
  parameter logic [15:0] OWNER_ID       = 16'h0001,
  parameter logic [15:0] LOCK_VALUE     = 16'h0001,
  parameter int unsigned BACKOFF_CYCLES = 16,
  parameter int unsigned MAX_RETRIES    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lock_req,
  input  logic        unlock_req,
  output logic        lock_granted,
  output logic        lock_busy,
  output logic        lock_fail,
  output logic        avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACQ_WR, S_ACQ_RD, S_BACKOFF,
    S_HELD, S_REL_WR, S_INIT_RD, S_INIT_WR
  } state_t;

  localparam logic [31:0] LOCK_WORD = {OWNER_ID, LOCK_VALUE};
  localparam logic [31:0] REL_WORD  = {OWNER_ID, 16'h0000};
  localparam logic [16:0] BO_LOAD   =
    17'(BACKOFF_CYCLES) + 17'(OWNER_ID[3:0]);
  localparam logic [8:0]  MAX_R     = 9'(MAX_RETRIES);

  state_t      r_state, w_next;
  logic [7:0]  r_retry, w_retry;
  logic [16:0] r_bo, w_bo;
  logic        r_fail, w_fail;
  logic        w_ready;
  logic [8:0]  w_tries;

`ifdef MUTEX_RESET_CLEAR_EN
  logic r_init_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_init_done <= 1'b0;
    else if ((r_state == S_INIT_RD || r_state == S_INIT_WR)
             && w_next == S_IDLE)
      r_init_done <= 1'b1;
  end

  assign w_ready = r_init_done;
`else
  assign w_ready = 1'b1;
`endif

  assign w_tries      = {1'b0, r_retry} + 9'd1;
  assign lock_fail    = r_fail;
  assign lock_granted = (r_state == S_HELD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_retry <= '0;
      r_bo    <= '0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_retry <= w_retry;
      r_bo    <= w_bo;
      r_fail  <= w_fail;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_retry       = r_retry;
    w_bo          = r_bo;
    w_fail        = 1'b0;
    lock_busy     = 1'b1;
    avm_address   = 1'b0;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = '0;
    unique case (r_state)
      S_IDLE: begin
        lock_busy = 1'b0;
        if (!w_ready) begin
          w_next = S_INIT_RD;
        end else if (lock_req) begin
          w_next  = S_ACQ_WR;
          w_retry = '0;
        end
      end
      S_ACQ_WR: begin
        avm_write     = 1'b1;
        avm_writedata = LOCK_WORD;
        if (!avm_waitrequest) w_next = S_ACQ_RD;
      end
      S_ACQ_RD: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          if (avm_readdata == LOCK_WORD) begin
            w_next = S_HELD;
          end else begin
            w_retry = (r_retry == 8'hFF) ? r_retry : w_tries[7:0];
            if (MAX_R != 9'd0 && w_tries == MAX_R) begin
              w_next = S_IDLE;
              w_fail = 1'b1;
            end else begin
              w_next = S_BACKOFF;
              w_bo   = BO_LOAD;
            end
          end
        end
      end
      S_BACKOFF: begin
        // Count reaches zero on the last idle cycle, so BO_LOAD idle cycles.
        if (r_bo <= 17'd1) begin
          w_next = S_ACQ_WR;
          w_bo   = '0;
        end else begin
          w_bo = r_bo - 17'd1;
        end
      end
      S_HELD: begin
        lock_busy = 1'b0;
        if (unlock_req) w_next = S_REL_WR;
      end
      S_REL_WR: begin
        avm_write     = 1'b1;
        avm_writedata = REL_WORD;
        if (!avm_waitrequest) w_next = S_IDLE;
      end
      S_INIT_RD: begin
        avm_address = 1'b1;
        avm_read    = 1'b1;
        if (!avm_waitrequest)
          w_next = avm_readdata[0] ? S_INIT_WR : S_IDLE;
      end
      S_INIT_WR: begin
        avm_address = 1'b1;
        avm_write   = 1'b1;
        if (!avm_waitrequest) w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mutex_lock_master.sv
// Directed + randomized bench for mutex_lock_master with an Avalon mutex
// slave model (write accepted when free or owner matches).
module tb_mutex_lock_master;

  localparam int BO   = 16 + 1;
  localparam int MAXR = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lock_req = 1'b0;
  logic        unlock_req = 1'b0;
  logic        lock_granted, lock_busy, lock_fail;
  logic        avm_address, avm_read, avm_write;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest;

  int errors = 0;
  int checks = 0;
  int stall_wr = 0;
  int stall_rd = 0;

  logic [31:0] mtx = '0;
  logic        flag = 1'b0;
  logic [31:0] mtx_val = '0;
  logic        mtx_go = 1'b0;
  logic        flag_val = 1'b0;
  logic        flag_go = 1'b0;
  int busy_cyc = 0;
  int wr0_cnt = 0;
  int rd0_cnt = 0;
  int a1_wr = 0;
  int a1_rd = 0;
  int fail_cnt = 0;
  int viol = 0;
  logic        p_wait = 1'b0;
  logic [34:0] p_bus = '0;

  mutex_lock_master dut (
    .clk(clk), .reset_n(reset_n),
    .lock_req(lock_req), .unlock_req(unlock_req),
    .lock_granted(lock_granted), .lock_busy(lock_busy),
    .lock_fail(lock_fail), .avm_address(avm_address),
    .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  assign avm_waitrequest = (avm_read || avm_write) &&
    (busy_cyc < (avm_write ? stall_wr : stall_rd));
  assign avm_readdata = avm_address ? {31'd0, flag} : mtx;

  always @(posedge clk) begin
    if (mtx_go) mtx <= mtx_val;
    if (flag_go) flag <= flag_val;
    if (!reset_n) begin
      busy_cyc <= 0;
      p_wait   <= 1'b0;
    end else begin
      if (lock_fail) fail_cnt <= fail_cnt + 1;
      if ((avm_read && avm_write) || (p_wait &&
          {avm_read, avm_write, avm_address, avm_writedata} !== p_bus))
        viol <= viol + 1;
      p_wait <= (avm_read || avm_write) && avm_waitrequest;
      p_bus  <= {avm_read, avm_write, avm_address, avm_writedata};
      if (avm_read || avm_write) begin
        if (avm_waitrequest) begin
          busy_cyc <= busy_cyc + 1;
        end else begin
          busy_cyc <= 0;
          if (avm_write && !avm_address) begin
            wr0_cnt <= wr0_cnt + 1;
            if (mtx[15:0] == 16'h0 || mtx[31:16] == avm_writedata[31:16])
              mtx <= avm_writedata;
          end
          if (avm_read && !avm_address) rd0_cnt <= rd0_cnt + 1;
          if (avm_write && avm_address) begin
            a1_wr <= a1_wr + 1;
            flag  <= avm_writedata[0];
          end
          if (avm_read && avm_address) a1_rd <= a1_rd + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edges from the request edge to grant/fail, from the protocol rules.
  function automatic int ref_lat(input int attempts);
    return 1 + attempts * (2 + stall_wr + stall_rd) + (attempts - 1) * BO;
  endfunction

  task automatic preset(input logic [31:0] v);
    mtx_val = v;
    mtx_go  = 1'b1;
    @(negedge clk);
    mtx_go  = 1'b0;
  endtask

  task automatic do_lock(output int lat);
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    lat = 1;
    while (!lock_granted && !lock_fail && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_unlock(output int lat);
    unlock_req = 1'b1;
    @(negedge clk);
    unlock_req = 1'b0;
    chk("unlock_grant_drop", lock_granted, 0);
    lat = 1;
    while (lock_busy && lat < 500) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (3) @(negedge clk);
    while (lock_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 500, 1);
  endtask

  initial begin
    int lat, w0, r0, f0, kind;
    logic [31:0] init_v;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {lock_granted, lock_busy, lock_fail, avm_read,
        avm_write, avm_address, avm_writedata}, 0);
`ifdef MUTEX_RESET_CLEAR_EN
    flag_val = 1'b1;
    flag_go  = 1'b1;
    @(negedge clk);
    flag_go  = 1'b0;
`endif
    reset_n = 1'b1;
    wait_idle();
`ifdef MUTEX_RESET_CLEAR_EN
    chk("init_flag_cleared", flag, 0);
    chk("init_a1_wr", a1_wr, 1);
    chk("init_a1_rd", a1_rd, 1);
`endif

    preset(32'h0);
    w0 = wr0_cnt;
    r0 = rd0_cnt;
    do_lock(lat);
    chk("free_lat", lat, 3);
    chk("free_grant_busy", {lock_granted, lock_busy}, 2'b10);
    chk("free_word", mtx, 32'h0001_0001);
    chk("free_xfers", {16'(wr0_cnt - w0), 16'(rd0_cnt - r0)}, 32'h0001_0001);

    w0 = wr0_cnt;
    lock_req = 1'b1;
    repeat (3) @(negedge clk);
    lock_req = 1'b0;
    chk("held_ignores_req", {lock_granted, 16'(wr0_cnt - w0)}, 17'h1_0000);

    do_unlock(lat);
    chk("unlock_lat", lat, 2);
    chk("unlock_word", mtx, 32'h0001_0000);

    stall_wr = 4;
    stall_rd = 4;
    do_lock(lat);
    chk("stall_lat", lat, 11);
    do_unlock(lat);
    chk("stall_unlock_lat", lat, 6);

    stall_wr = 0;
    stall_rd = 0;
    preset(32'h0002_0005);
    f0 = fail_cnt;
    do_lock(lat);
    chk("contest_lat", lat, ref_lat(MAXR));
    chk("contest_fail", {lock_fail, lock_granted, lock_busy}, 3'b100);
    @(negedge clk);
    chk("contest_pulse", {lock_fail, 16'(fail_cnt - f0)}, 17'h0_0001);
    chk("contest_word", mtx, 32'h0002_0005);

    for (int i = 0; i < 6; i++) begin
      stall_wr = $urandom_range(0, 5);
      stall_rd = $urandom_range(0, 5);
      kind = $urandom_range(0, 2);
      init_v = (kind == 0) ? {16'($urandom), 16'h0} :
               (kind == 1) ? {16'h0001, 16'($urandom_range(1, 65535))} :
               {16'($urandom_range(2, 65535)), 16'($urandom_range(1, 65535))};
      preset(init_v);
      f0 = fail_cnt;
      do_lock(lat);
      if (kind == 2) begin
        chk("rnd_fail_lat", lat, ref_lat(MAXR));
        @(negedge clk);
        chk("rnd_fail_state", {lock_granted, lock_busy,
            16'(fail_cnt - f0), mtx}, {2'b00, 16'd1, init_v});
      end else begin
        chk("rnd_grant_lat", lat, ref_lat(1));
        chk("rnd_grant_word", {lock_granted, mtx}, {1'b1, 32'h0001_0001});
        do_unlock(lat);
        chk("rnd_unlock_lat", lat, 2 + stall_wr);
      end
    end

    stall_wr = 0;
    stall_rd = 0;
    preset(32'h0);
    lock_req   = 1'b1;
    unlock_req = 1'b1;
    @(negedge clk);
    lock_req   = 1'b0;
    unlock_req = 1'b0;
    chk("both_req_lock_wins", avm_write, 1);
    repeat (2) @(negedge clk);
    chk("both_req_granted", lock_granted, 1);
    do_unlock(lat);

    preset(32'h0002_0005);
    f0 = fail_cnt;
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("backoff_quiet", {lock_busy, avm_read, avm_write}, 3'b100);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outputs", {lock_granted, lock_busy, lock_fail,
        avm_read, avm_write, avm_address, avm_writedata}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {lock_granted, lock_fail}, 0);
    wait_idle();
    chk("post_reset_no_fail", fail_cnt - f0, 0);

    preset(32'h0001_0003);
    do_lock(lat);
    chk("owner_match_lat", lat, 3);
    chk("owner_match_word", mtx, 32'h0001_0001);
    do_unlock(lat);

    chk("bus_protocol", viol, 0);
`ifdef MUTEX_RESET_CLEAR_EN
    chk("a1_accesses", {16'(a1_wr), 16'(a1_rd)}, 32'h0001_0002);
`else
    chk("a1_accesses", {16'(a1_wr), 16'(a1_rd)}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
